// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, plus MTHI/MTLO writes.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state, state_nxt;
  logic              load, step, finish;
  logic              is_div, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [CW-1:0]     cnt;

  // Operand capture: signed ops take two's-complement magnitudes
  logic            op_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  assign op_signed = (op == 3'd0) || (op == 3'd2);
  assign a_neg     = op_signed && a[XLEN-1];
  assign b_neg     = op_signed && b[XLEN-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply step: conditional add of |a| into the upper half, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: quotient bits shift into acc[XLEN-1:0]
  logic [XLEN:0]   rem_sh, rem_nxt;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] q_nxt;
  assign rem_sh   = {rem[XLEN-1:0], acc[XLEN-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, mag_b};
  assign div_ok   = ~div_diff[XLEN+1];
  assign rem_nxt  = div_ok ? div_diff[XLEN:0] : rem_sh;
  assign q_nxt    = {acc[XLEN-2:0], div_ok};

  // Final sign fix-up
  logic              neg_res, b_zero;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, a_orig;
  assign neg_res  = sign_a ^ sign_b;
  assign b_zero   = (mag_b == '0);
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign a_orig   = sign_a ? -mag_a : mag_a;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (start && (op <= 3'd3)) begin
        load      = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(XLEN - 1)) state_nxt = FIN;
      end
      FIN: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      rem         <= '0;
      cnt         <= '0;
    end else begin
      busy        <= (state_nxt != IDLE);
      done        <= finish;
      div_by_zero <= finish && is_div && b_zero;
      if (load) begin
        is_div <= op[1];
        sign_a <= a_neg;
        sign_b <= b_neg;
        mag_a  <= a_mag;
        mag_b  <= b_mag;
        acc    <= {XLEN'(0), (op[1] ? a_mag : b_mag)};
        rem    <= '0;
        cnt    <= '0;
      end
      if (step) begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          acc <= {acc[2*XLEN-1:XLEN], q_nxt};
          rem <= rem_nxt;
        end else begin
          acc <= mul_nxt;
        end
      end
      if (finish) begin
        if (!is_div) begin
          hi <= prod_fix[2*XLEN-1:XLEN];
          lo <= prod_fix[XLEN-1:0];
        end else if (b_zero) begin
          hi <= a_orig;
          lo <= '1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
      // Moves to HI/LO only land while idle
      if (state == IDLE && start && op == 3'd4) hi <= a;
      if (state == IDLE && start && op == 3'd5) lo <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            busy, done, div_by_zero;
  logic [XLEN-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request for one edge; caller must be just after a rising edge
  task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] xa,
                     input logic [31:0] xb, input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz);
    int n;
    issue(o, xa, xb);
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " done_drop"}, 64'(done), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 60);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(XLEN + 1));
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " dz"}, 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    logic [31:0] hi_prev;
    logic        saw_done;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz", 64'(div_by_zero), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);

    // Each run is issued in the previous run's done cycle (back-to-back)
    run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mult_neg",  3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("mult_min",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run("div_neg",   3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("divu",      3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
    run("divu_zero", 3'd3, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1);
    run("div_zero",  3'd2, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    run("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run("div_negb",  3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);

    issue(3'd5, 32'h12345678, 32'h0);
    check("mtlo lo", 64'(lo), 64'h12345678);
    check("mtlo hi", 64'(hi), 64'h00000001);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);
    issue(3'd4, 32'hCAFEF00D, 32'h0);
    check("mthi hi", 64'(hi), 64'hCAFEF00D);
    issue(3'd6, 32'hDEADBEEF, 32'h1);
    check("nop hi", 64'(hi), 64'hCAFEF00D);
    check("nop lo", 64'(lo), 64'h12345678);
    check("nop busy", 64'(busy), 64'd0);

    // Abort: MULTU in flight, MTHI ignored while busy, then reset
    hi_prev = hi;
    issue(3'd1, 32'd3, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    issue(3'd4, 32'hDEADBEEF, 32'h0);
    check("mthi_busy hi", 64'(hi), 64'(hi_prev));
    check("mthi_busy busy", 64'(busy), 64'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no_done", 64'(saw_done), 64'd0);
    check("abort hi_hold", 64'(hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
